systolic_skew_feeder: RTL and testbench

- Left-edge transmitter for the systolic array. Each row module consumes an A-operand stream on its left input.
- Buffers one tile of A: num_of_rows rows by depth_k inner-dimension elements, loaded one column per beat through a valid/ready interface.
- Replays the tile diagonally skewed, so row r lags row r-1 by one cycle, with zero padding outside each row's window.
- Output lane r drives the in_left_tot of row r in the array.

---
 rtl/systolic_skew_feeder.sv | 128 ++++++++++++
 tb/tb_systolic_skew_feeder.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Left-edge transmitter for the systolic array. Buffers one A tile
//   (num_of_rows x depth_k) loaded one column per beat, then replays it
//   diagonally skewed so lane r lags lane r-1 by one step, with zeros
//   outside each row's window.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   LOAD   | accepting column beats into the tile buffer (in_ready=1)
//   STREAM | issuing one skew step per cycle while advance=1 (busy=1)
//   DONE   | one cycle: clear lanes, raise done next cycle, go to LOAD
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   in_valid      loader presents a column beat
//   in_ready      feeder accepts a beat (state LOAD)
//   in_data       lane r = A[r][k] for the current column k
//   advance       array clock-enable; 0 freezes the stream
//   out_left_tot  lane r drives the left input of array row r
//   out_valid     out_left_tot carries a new skew step this cycle
//   busy          high while streaming
//   done          one-cycle pulse after the last skew step
module systolic_skew_feeder #(
  parameter int num_of_rows = 4,
  parameter int data_width  = 8,
  parameter int depth_k     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [data_width*num_of_rows-1:0] in_data,
  input  logic                              advance,
  output logic [data_width*num_of_rows-1:0] out_left_tot,
  output logic                              out_valid,
  output logic                              busy,
  output logic                              done
);

  localparam int num_steps = depth_k + num_of_rows - 1;
  localparam int kw        = $clog2(depth_k);
  localparam int tw        = $clog2(num_steps);
  localparam logic [kw-1:0] k_last = kw'(depth_k - 1);
  localparam logic [tw-1:0] t_last = tw'(num_steps - 1);

  typedef enum logic [1:0] {LOAD, STREAM, DONE} state_t;

  state_t                             state;
  logic [kw-1:0]                      k_cnt;
  logic [tw-1:0]                      t_cnt;
  logic [data_width-1:0]              tile [num_of_rows][depth_k];
  logic [data_width*num_of_rows-1:0]  step;
  logic                               accept;

  assign in_ready = (state == LOAD);
  assign busy     = (state == STREAM);
  assign accept   = in_valid && in_ready;

  // Tile contents are don't-care after reset, so the buffer carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < num_of_rows; r++) begin
        tile[r][k_cnt] <= in_data[r*data_width +: data_width];
      end
    end
  end

  // Skew step for t = t_cnt: lane r shows A[r][t-r] inside its window, else 0.
  always_comb begin
    step = '0;
    for (int r = 0; r < num_of_rows; r++) begin
      if ((int'(t_cnt) >= r) && (int'(t_cnt) - r < depth_k)) begin
        step[r*data_width +: data_width] = tile[r][kw'(int'(t_cnt) - r)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= LOAD;
      k_cnt        <= '0;
      t_cnt        <= '0;
      out_left_tot <= '0;
      out_valid    <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          out_valid <= 1'b0;
          if (accept) begin
            if (k_cnt == k_last) begin
              k_cnt <= '0;
              t_cnt <= '0;
              state <= STREAM;
            end else begin
              k_cnt <= k_cnt + 1'b1;
            end
          end
        end
        STREAM: begin
          if (advance) begin
            out_left_tot <= step;
            out_valid    <= 1'b1;
            if (t_cnt == t_last) begin
              t_cnt <= '0;
              state <= DONE;
            end else begin
              t_cnt <= t_cnt + 1'b1;
            end
          end else begin
            // Frozen array: lanes keep their last value, no new step.
            out_valid <= 1'b0;
          end
        end
        DONE: begin
          out_left_tot <= '0;
          out_valid    <= 1'b0;
          done         <= 1'b1;
          state        <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Testbench for systolic_skew_feeder: drives tiles through the valid/ready
// loader port, records every cycle of the output, and compares the stream
// against a reference built directly from the skew rule
// lane r at step t = A[r][t-r] inside the window, else 0.
module tb_systolic_skew_feeder;
  localparam int R  = 4;
  localparam int DW = 8;
  localparam int K  = 4;
  localparam int S  = K + R - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [R*DW-1:0] in_data = '0;
  logic            advance = 1'b1;
  logic [R*DW-1:0] out_left_tot;
  logic            out_valid;
  logic            busy;
  logic            done;

  int vectors = 0;
  int errors  = 0;

  logic [DW-1:0]   a      [R][K];
  logic [DW-1:0]   a_next [R][K];
  logic [R*DW-1:0] out_q[$];
  bit              vld_q[$];
  bit              done_q[$];
  bit              rdy_q[$];
  bit              busy_q[$];
  int              last_acc;
  bit              timed_out;

  systolic_skew_feeder #(.num_of_rows(R), .data_width(DW), .depth_k(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .advance(advance), .out_left_tot(out_left_tot),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [R*DW-1:0] model_step(int t);
    logic [R*DW-1:0] v;
    v = '0;
    for (int r = 0; r < R; r++)
      if (t - r >= 0 && t - r < K) v[r*DW +: DW] = a[r][t-r];
    return v;
  endfunction

  function automatic logic [R*DW-1:0] column(int k, bit nxt);
    logic [R*DW-1:0] c;
    c = '0;
    for (int r = 0; r < R; r++) c[r*DW +: DW] = nxt ? a_next[r][k] : a[r][k];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fixed_tile();
    for (int r = 0; r < R; r++)
      for (int k = 0; k < K; k++) a[r][k] = DW'(8'h10 * r + k + 1);
  endtask

  task automatic rand_tiles();
    for (int r = 0; r < R; r++)
      for (int k = 0; k < K; k++) begin
        a[r][k]      = DW'($urandom);
        a_next[r][k] = DW'($urandom);
      end
  endtask

  // Loads the tile in a[] and logs every cycle until done is seen.
  // gap_beat/gap_len: drop in_valid for gap_len cycles after that beat.
  // stall_after/stall_len: drop advance for stall_len cycles once that many
  // valid steps were observed. hold_next: keep presenting a_next column 0.
  task automatic run_tile(input int gap_beat, input int gap_len, input int stall_after,
                          input int stall_len, input bit hold_next);
    int k; int gap; int nv; int stall; int cyc; bit stalled; bit acc;
    k = 0; gap = 0; nv = 0; stall = 0; cyc = 0; stalled = 0;
    out_q.delete(); vld_q.delete(); done_q.delete(); rdy_q.delete(); busy_q.delete();
    last_acc = -1;
    timed_out = 1'b1;
    while (cyc < 200) begin
      if (k < K && gap == 0) begin
        in_valid = 1'b1; in_data = column(k, 1'b0);
      end else if (k >= K && hold_next) begin
        in_valid = 1'b1; in_data = column(0, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      advance = (stall == 0);
      acc = in_valid && in_ready && (k < K);
      tick();
      cyc++;
      out_q.push_back(out_left_tot);
      vld_q.push_back(out_valid);
      done_q.push_back(done);
      rdy_q.push_back(in_ready);
      busy_q.push_back(busy);
      if (acc) begin
        if (k == gap_beat) gap = gap_len;
        k++;
        last_acc = out_q.size() - 1;
      end else if (gap > 0) begin
        gap--;
      end
      if (stall > 0) stall--;
      if (out_valid) begin
        nv++;
        if (!stalled && nv == stall_after) begin
          stall = stall_len;
          stalled = 1'b1;
        end
      end
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (!hold_next) in_valid = 1'b0;
    advance = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({out_left_tot, out_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b want 0", out_left_tot, out_valid, busy, done);
    end
    #20;
    rst = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    set_fixed_tile();
    run_tile(-1, 0, -1, 0, 1'b0);
    vectors++;
    if (timed_out !== 1'b0 || last_acc != 3 || out_q.size() != last_acc + 9) begin
      errors++;
      $display("FAIL b2b_timing: timeout=%b last_acc=%0d len=%0d want 0/3/12",
               timed_out, last_acc, out_q.size());
    end
    vectors++;
    if (rdy_q[3] !== 1'b0 || busy_q[3] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stream_flags: in_ready=%b busy=%b want 0/1", rdy_q[3], busy_q[3]);
    end
    for (int i = 1; i <= S; i++) begin
      vectors++;
      if (vld_q[3+i] !== 1'b1 || out_q[3+i] !== model_step(i - 1)) begin
        errors++;
        $display("FAIL b2b_step%0d: got %b/%h want 1/%h", i - 1, vld_q[3+i], out_q[3+i], model_step(i - 1));
      end
    end
    vectors++;
    if (out_q[4] !== 32'h00000001 || out_q[7] !== 32'h31221304 || out_q[10] !== 32'h34000000) begin
      errors++;
      $display("FAIL b2b_plan_steps: t0=%h t3=%h t6=%h want 00000001/31221304/34000000",
               out_q[4], out_q[7], out_q[10]);
    end
    vectors++;
    if (done_q[11] !== 1'b1 || rdy_q[11] !== 1'b1 || vld_q[11] !== 1'b0 || out_q[11] !== '0) begin
      errors++;
      $display("FAIL b2b_done: done=%b in_ready=%b valid=%b out=%h want 1/1/0/0",
               done_q[11], rdy_q[11], vld_q[11], out_q[11]);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_gap();
    int n;
    set_fixed_tile();
    run_tile(1, 3, -1, 0, 1'b0);
    vectors++;
    if (timed_out !== 1'b0 || last_acc != 6) begin
      errors++;
      $display("FAIL gap_accept: timeout=%b last_acc=%0d want 0/6", timed_out, last_acc);
    end
    n = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      if (vld_q[i]) begin
        vectors++;
        if (i != last_acc + 1 + n || out_q[i] !== model_step(n)) begin
          errors++;
          $display("FAIL gap_step%0d: idx=%0d got %h want idx=%0d %h", n, i, out_q[i], last_acc + 1 + n, model_step(n));
        end
        n++;
      end
    end
    vectors++;
    if (n != S) begin
      errors++;
      $display("FAIL gap_count: got %0d steps want %0d", n, S);
    end
  endtask

  task automatic test_stall();
    int n;
    set_fixed_tile();
    run_tile(-1, 0, 3, 2, 1'b0);
    vectors++;
    if (timed_out !== 1'b0 || out_q.size() != last_acc + 11) begin
      errors++;
      $display("FAIL stall_timing: timeout=%b len=%0d want 0/%0d", timed_out, out_q.size(), last_acc + 11);
    end
    for (int i = 4; i <= 5; i++) begin
      vectors++;
      if (vld_q[last_acc+i] !== 1'b0 || out_q[last_acc+i] !== 32'h00211203) begin
        errors++;
        $display("FAIL stall_hold: got %b/%h want 0/00211203", vld_q[last_acc+i], out_q[last_acc+i]);
      end
    end
    vectors++;
    if (vld_q[last_acc+6] !== 1'b1 || out_q[last_acc+6] !== 32'h31221304) begin
      errors++;
      $display("FAIL stall_resume: got %b/%h want 1/31221304", vld_q[last_acc+6], out_q[last_acc+6]);
    end
    n = 0;
    for (int i = 0; i < out_q.size(); i++) if (vld_q[i]) n++;
    vectors++;
    if (n != S) begin
      errors++;
      $display("FAIL stall_count: got %0d steps want %0d", n, S);
    end
  endtask

  task automatic test_stream_hold();
    int n;
    rand_tiles();
    run_tile(-1, 0, -1, 0, 1'b1);
    n = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      if (vld_q[i]) begin
        vectors++;
        if (out_q[i] !== model_step(n)) begin
          errors++;
          $display("FAIL hold_tile1_step%0d: got %h want %h", n, out_q[i], model_step(n));
        end
        n++;
      end
    end
    vectors++;
    if (n != S || timed_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_tile1_count: got %0d steps timeout=%b want %0d/0", n, timed_out, S);
    end
    for (int i = last_acc; i < out_q.size() - 1; i++) begin
      vectors++;
      if (rdy_q[i] !== 1'b0) begin
        errors++;
        $display("FAIL hold_in_ready: idx=%0d got %b want 0", i, rdy_q[i]);
      end
    end
    a = a_next;
    run_tile(-1, 0, -1, 0, 1'b0);
    vectors++;
    if (done_q[0] !== 1'b0 || last_acc != 3 || timed_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_tile2_load: done0=%b last_acc=%0d timeout=%b want 0/3/0", done_q[0], last_acc, timed_out);
    end
    n = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      if (vld_q[i]) begin
        vectors++;
        if (out_q[i] !== model_step(n)) begin
          errors++;
          $display("FAIL hold_tile2_step%0d: got %h want %h", n, out_q[i], model_step(n));
        end
        n++;
      end
    end
    vectors++;
    if (n != S) begin
      errors++;
      $display("FAIL hold_tile2_count: got %0d steps want %0d", n, S);
    end
  endtask

  task automatic test_reset_mid_stream();
    int nv; int cyc; int n;
    set_fixed_tile();
    for (int k = 0; k < K; k++) begin
      in_valid = 1'b1;
      in_data  = column(k, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    nv = 0; cyc = 0;
    while (nv < 5 && cyc < 20) begin
      tick();
      cyc++;
      if (out_valid) nv++;
    end
    vectors++;
    if (nv != 5 || out_left_tot !== 32'h32231400) begin
      errors++;
      $display("FAIL rst_pre_t4: steps=%0d out=%h want 5/32231400", nv, out_left_tot);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({out_left_tot, out_valid, busy, done} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async_clear: got %h/%b/%b/%b ready=%b want 0/0/0/0 ready=1",
               out_left_tot, out_valid, busy, done, in_ready);
    end
    #10 rst = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    rand_tiles();
    run_tile(-1, 0, -1, 0, 1'b0);
    n = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      if (vld_q[i]) begin
        vectors++;
        if (i != last_acc + 1 + n || out_q[i] !== model_step(n)) begin
          errors++;
          $display("FAIL rst_fresh_step%0d: idx=%0d got %h want %h", n, i, out_q[i], model_step(n));
        end
        n++;
      end
    end
    vectors++;
    if (n != S || last_acc != 3) begin
      errors++;
      $display("FAIL rst_fresh_count: steps=%0d last_acc=%0d want %0d/3", n, last_acc, S);
    end
  endtask

  task automatic test_random();
    int gb; int gl; int sa; int sl; int n; int first; int last; int span;
    for (int it = 0; it < 8; it++) begin
      rand_tiles();
      gb = $urandom_range(0, 2);
      gl = $urandom_range(0, 3);
      sa = $urandom_range(1, 7);
      sl = $urandom_range(1, 3);
      run_tile(gb, gl, sa, sl, 1'b0);
      n = 0; first = -1; last = -1;
      for (int i = 0; i < out_q.size(); i++) begin
        if (vld_q[i]) begin
          vectors++;
          if (out_q[i] !== model_step(n)) begin
            errors++;
            $display("FAIL rand%0d_step%0d: got %h want %h", it, n, out_q[i], model_step(n));
          end
          if (first < 0) first = i;
          last = i;
          n++;
        end else if (first >= 0 && n < S) begin
          vectors++;
          if (out_q[i] !== model_step(n - 1)) begin
            errors++;
            $display("FAIL rand%0d_hold: idx=%0d got %h want %h", it, i, out_q[i], model_step(n - 1));
          end
        end
      end
      span = S - 1 + ((sa < S) ? sl : 0);
      vectors++;
      if (n != S || first != last_acc + 1 || last - first != span || timed_out !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_shape: steps=%0d first=%0d last=%0d timeout=%b want %0d/%0d/%0d/0",
                 it, n, first, last, timed_out, S, last_acc + 1, last_acc + 1 + span);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_stall();
    test_stream_hold();
    test_reset_mid_stream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
